// File: rtl/ddr2_wr_split_pkg.sv
// rtl/ddr2_wr_split_pkg.sv - shared geometry defaults and FSM state type for ddr2_wr_split
package ddr2_wr_split_pkg;

    localparam int DEF_COL_BITS = 10;
    localparam int DEF_ROW_BITS = 13;
    localparam int DEF_BA_BITS  = 2;
    localparam int DEF_DQ_BITS  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WAITB = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/ddr2_wr_split.sv
// rtl/ddr2_wr_split.sv - splits write bursts into sub-bursts that never cross a DDR2 row
//
// Ports:
//   ck, rst                          clock, asynchronous active-high reset
//   s_aw{valid,ready,addr,len}       incoming burst address (addr bit 0 ignored, len = beats-1)
//   s_w{valid,ready,last,data}       incoming write data
//   s_b{valid,ready}                 one merged response per incoming burst
//   m_aw{valid,ready,addr,len}       sub-burst address towards ddr2_ctrl
//   m_w{valid,ready,last,data}       sub-burst data, wlast regenerated per sub-burst
//   m_b{valid,ready}                 one response per sub-burst
//   err                              sticky s_wlast mismatch, only with DDR2_WSPLIT_LAST_CHK_EN
module ddr2_wr_split
    import ddr2_wr_split_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ROW_BITS + DEF_COL_BITS + DEF_BA_BITS,
    parameter int DATA_WIDTH = 2 * DEF_DQ_BITS,
    parameter int COL_BITS   = DEF_COL_BITS
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic                  s_wlast,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [7:0]            m_awlen,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic                  m_wlast,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_bvalid,
    output logic                  m_bready
`ifdef DDR2_WSPLIT_LAST_CHK_EN
    ,
    output logic                  err
`endif
);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [8:0]            left;
    logic [8:0]            nsub;
    logic [8:0]            bcnt;
    logic [7:0]            beat;
    logic [7:0]            len_q;

    logic [8:0]            sub;
    logic [8:0]            left_nx;
    logic [8:0]            bcnt_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic                  last_beat;
    logic                  w_hs;
    logic                  b_hs;

    // Sub-burst length minus one: the smaller of the beats still owed and the
    // beats left before the column field wraps (two columns per beat).
    function automatic logic [7:0] calc_len(input logic [COL_BITS-1:0] col,
                                            input logic [8:0]          rem);
        logic [COL_BITS:0] row_beats;
        row_beats = ({1'b1, {COL_BITS{1'b0}}} - {1'b0, col}) >> 1;
        if (int'(rem) <= int'(row_beats))
            calc_len = 8'(int'(rem) - 1);
        else
            calc_len = 8'(int'(row_beats) - 1);
    endfunction

    assign sub       = {1'b0, len_q} + 9'd1;
    assign left_nx   = left - sub;
    assign addr_nx   = cur_addr + ADDR_WIDTH'({sub, 1'b0});
    assign last_beat = (beat == len_q);
    assign w_hs      = (state == ST_DATA) && s_wvalid && m_wready;
    assign b_hs      = m_bvalid && m_bready;
    // A response landing in the same cycle as the final beat must already count.
    assign bcnt_nx   = bcnt + {8'd0, b_hs};

    assign m_awaddr  = cur_addr;
    assign m_awlen   = len_q;
    assign m_wdata   = s_wdata;

    always_comb begin
        state_nx  = state;
        s_awready = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        s_wready  = 1'b0;
        m_wlast   = 1'b0;
        s_bvalid  = 1'b0;
        m_bready  = 1'b1;
        case (state)
            ST_IDLE: begin
                s_awready = 1'b1;
                m_bready  = 1'b0;
                if (s_awvalid)
                    state_nx = ST_ADDR;
            end
            ST_ADDR: begin
                m_awvalid = 1'b1;
                if (m_awready)
                    state_nx = ST_DATA;
            end
            ST_DATA: begin
                m_wvalid = s_wvalid;
                s_wready = m_wready;
                m_wlast  = last_beat;
                if (w_hs && last_beat) begin
                    if (left_nx != 9'd0)
                        state_nx = ST_ADDR;
                    else if (bcnt_nx == nsub)
                        state_nx = ST_RESP;
                    else
                        state_nx = ST_WAITB;
                end
            end
            ST_WAITB: begin
                if (bcnt_nx == nsub)
                    state_nx = ST_RESP;
            end
            ST_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_addr <= '0;
            left     <= '0;
            nsub     <= '0;
            bcnt     <= '0;
            beat     <= '0;
            len_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && s_awvalid) begin
                cur_addr <= {s_awaddr[ADDR_WIDTH-1:1], 1'b0};
                left     <= {1'b0, s_awlen} + 9'd1;
                nsub     <= '0;
                len_q    <= calc_len(s_awaddr[COL_BITS-1:0] & ~COL_BITS'(1),
                                     {1'b0, s_awlen} + 9'd1);
            end
            if (state == ST_ADDR && m_awready) begin
                nsub <= nsub + 9'd1;
                beat <= '0;
            end
            if (w_hs) begin
                beat <= beat + 8'd1;
                if (last_beat) begin
                    cur_addr <= addr_nx;
                    left     <= left_nx;
                    if (left_nx != 9'd0)
                        len_q <= calc_len(addr_nx[COL_BITS-1:0], left_nx);
                end
            end
            if (state == ST_RESP && s_bready)
                bcnt <= '0;
            else
                bcnt <= bcnt_nx;
        end
    end

    logic unused_bits;
`ifdef DDR2_WSPLIT_LAST_CHK_EN
    assign unused_bits = s_awaddr[0];

    // The original burst ends on the last beat of the sub-burst that drains 'left'.
    always_ff @(posedge ck or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (w_hs && (s_wlast != ((left == sub) && last_beat)))
            err <= 1'b1;
    end
`else
    assign unused_bits = s_awaddr[0] ^ s_wlast;
`endif

endmodule

// File: tb/tb_ddr2_wr_split.sv
// tb/tb_ddr2_wr_split.sv - scoreboard bench for ddr2_wr_split (COL_BITS=10)
module tb_ddr2_wr_split;

    localparam int AW = 25;
    localparam int DW = 32;
    localparam int CB = 10;

    logic          ck = 1'b0;
    logic          rst;
    logic          s_awvalid, s_awready;
    logic [AW-1:0] s_awaddr;
    logic [7:0]    s_awlen;
    logic          s_wvalid, s_wready, s_wlast;
    logic [DW-1:0] s_wdata;
    logic          s_bvalid, s_bready;
    logic          m_awvalid, m_awready;
    logic [AW-1:0] m_awaddr;
    logic [7:0]    m_awlen;
    logic          m_wvalid, m_wready, m_wlast;
    logic [DW-1:0] m_wdata;
    logic          m_bvalid, m_bready;
`ifdef DDR2_WSPLIT_LAST_CHK_EN
    logic          err;
`endif

    always #5 ck = ~ck;

    ddr2_wr_split #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COL_BITS(CB)) dut (
        .ck(ck), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef DDR2_WSPLIT_LAST_CHK_EN
        , .err(err)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [AW+7:0] exp_aw[$];
    logic [DW:0]   exp_w[$];
    int            exp_b[$];

    int            pend_b = 0;
    int            mb_cnt = 0;
    int            aw_stall = 0;
    bit            wtoggle = 1'b0;
    bit            aw_waiting = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_len;

    // Downstream model: accepts sub-bursts, returns one response per sub-burst,
    // and checks everything the DUT emits against the scoreboard.
    initial begin
        logic [AW+7:0] ea;
        logic [DW:0]   ew;
        int            eb;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        m_bvalid  = 1'b0;
        forever begin
            @(negedge ck);
            if (rst) begin
                pend_b     = 0;
                mb_cnt     = 0;
                aw_waiting = 1'b0;
            end else begin
                if (m_awvalid && !m_awready) begin
                    if (aw_waiting) begin
                        check("awaddr_stable", m_awaddr, hold_addr);
                        check("awlen_stable", m_awlen, hold_len);
                    end else begin
                        aw_waiting = 1'b1;
                        hold_addr  = m_awaddr;
                        hold_len   = m_awlen;
                    end
                    if (aw_stall > 0) aw_stall--;
                end
                if (m_awvalid && m_awready) begin
                    if (aw_waiting) check("awaddr_stable", m_awaddr, hold_addr);
                    aw_waiting = 1'b0;
                    if (exp_aw.size() == 0) check("aw_unexpected", m_awvalid, 0);
                    else begin
                        ea = exp_aw.pop_front();
                        check("m_awaddr", m_awaddr, ea[AW+7:8]);
                        check("m_awlen", m_awlen, ea[7:0]);
                    end
                end
                if (m_wvalid && m_wready) begin
                    if (exp_w.size() == 0) check("w_unexpected", m_wvalid, 0);
                    else begin
                        ew = exp_w.pop_front();
                        check("m_wdata", m_wdata, ew[DW-1:0]);
                        check("m_wlast", m_wlast, ew[DW]);
                    end
                    if (m_wlast) pend_b++;
                end
                if (m_bvalid && m_bready) begin
                    pend_b--;
                    mb_cnt++;
                end
                if (s_bvalid && s_bready) begin
                    if (exp_b.size() == 0) check("b_unexpected", s_bvalid, 0);
                    else begin
                        eb = exp_b.pop_front();
                        check("m_b_before_s_b", mb_cnt, eb);
                    end
                    mb_cnt = 0;
                end
            end
            @(posedge ck);
            #1;
            m_awready = (aw_stall == 0);
            m_wready  = wtoggle ? !m_wready : 1'b1;
            m_bvalid  = (pend_b > 0);
        end
    end

    task automatic check_reset();
        check("rst_s_awready", s_awready, 1);
        check("rst_m_awvalid", m_awvalid, 0);
        check("rst_m_wvalid", m_wvalid, 0);
        check("rst_m_wlast", m_wlast, 0);
        check("rst_s_wready", s_wready, 0);
        check("rst_s_bvalid", s_bvalid, 0);
        check("rst_m_awaddr", m_awaddr, 0);
        check("rst_m_awlen", m_awlen, 0);
        check("rst_m_bready", m_bready, 0);
`ifdef DDR2_WSPLIT_LAST_CHK_EN
        check("rst_err", err, 0);
`endif
    endtask

    // Entered and left at 1 time unit after a rising edge. Returns the number of
    // cycles from the first to the last data beat handshake.
    task automatic send(input logic [AW-1:0] addr, input int len, input int bad_beat,
                        input int abort_at, output int span);
        logic [DW-1:0] dq[256];
        logic [AW-1:0] a;
        int            left, rb, sub, idx, nsubs, t, cyc, first, lastc;
        for (int i = 0; i <= len; i++) dq[i] = $urandom;
        a = addr;
        a[0] = 1'b0;
        left = len + 1;
        idx = 0;
        nsubs = 0;
        while (left > 0) begin
            rb  = ((1 << CB) - int'(a[CB-1:0])) / 2;
            sub = (left < rb) ? left : rb;
            exp_aw.push_back({a, 8'(sub - 1)});
            for (int j = 0; j < sub; j++) begin
                exp_w.push_back({j == sub - 1, dq[idx]});
                idx++;
            end
            a = a + AW'(2 * sub);
            left -= sub;
            nsubs++;
        end
        exp_b.push_back(nsubs);

        s_awaddr  = addr;
        s_awlen   = 8'(len);
        s_awvalid = 1'b1;
        t = 0;
        do begin @(negedge ck); t++; end while (!s_awready && t < 200);
        if (!s_awready) check("s_awready_timeout", s_awready, 1);
        @(posedge ck); #1;
        s_awvalid = 1'b0;
        @(negedge ck);
        check("aw_latency", m_awvalid, 1);
        @(posedge ck); #1;

        cyc = 0; first = -1; lastc = 0;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) begin
                s_wvalid = 1'b0;
                span = 0;
                return;
            end
            s_wdata  = dq[i];
            s_wlast  = (i == len) ^ (i == bad_beat);
            s_wvalid = 1'b1;
            t = 0;
            do begin @(negedge ck); t++; cyc++; end while (!s_wready && t < 200);
            if (!s_wready) check("s_wready_timeout", s_wready, 1);
            if (first < 0) first = cyc;
            lastc = cyc;
            @(posedge ck); #1;
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        span = lastc - first + 1;

        t = 0;
        do begin @(negedge ck); t++; end while (!s_bvalid && t < 200);
        if (!s_bvalid) check("s_bvalid_timeout", s_bvalid, 1);
        @(posedge ck); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int span;
        rst = 1'b1;
        s_awvalid = 1'b0; s_awaddr = '0; s_awlen = '0;
        s_wvalid = 1'b0; s_wlast = 1'b0; s_wdata = '0;
        s_bready = 1'b1;
        repeat (2) @(negedge ck);
        check_reset();
        @(posedge ck); #1;
        rst = 1'b0;
        @(posedge ck); #1;

        send(25'(5*1024 + 0), 7, -1, -1, span);
        check("aligned_span", span, 8);
        send(25'(5*1024 + 1020), 7, -1, -1, span);
        check("row_cross_span", span, 9);
        send(25'(5*1024 + 1022), 0, -1, -1, span);
        send(25'(5*1024 + 1021), 3, -1, -1, span);
        send(25'(32'h1FF_FFFC), 5, -1, -1, span);

        wtoggle  = 1'b1;
        aw_stall = 3;
        @(posedge ck); #1;
        @(posedge ck); #1;
        send(25'(7*1024 + 100), 7, -1, -1, span);
        check("bp_span_le_16", span <= 16, 1);
        wtoggle = 1'b0;
        @(posedge ck); #1;
        @(posedge ck); #1;

        send(25'(9*1024 + 0), 7, -1, 3, span);
        rst = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        exp_b.delete();
        @(negedge ck);
        check_reset();
        @(posedge ck); #1;
        rst = 1'b0;
        @(posedge ck); #1;
        send(25'(9*1024 + 0), 3, -1, -1, span);
        check("post_reset_span", span, 4);

`ifdef DDR2_WSPLIT_LAST_CHK_EN
        @(negedge ck);
        check("err_clean", err, 0);
        @(posedge ck); #1;
        send(25'(11*1024 + 8), 7, 3, -1, span);
        @(negedge ck);
        check("err_sticky", err, 1);
        repeat (3) @(posedge ck);
        #1;
        @(negedge ck);
        check("err_held", err, 1);
        @(posedge ck); #1;
`endif

        repeat (4) @(posedge ck);
        #1;
        check("aw_queue_empty", exp_aw.size(), 0);
        check("w_queue_empty", exp_w.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
